// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral (generator and capture).
//   pwm_cap_state_t    : capture state machine states
//   PWM_SYNC_MIN       : minimum synchronizer depth for asynchronous inputs
//   PWM_RESOLUTION_DEF : default counter / compare width
package pwm_pkg;

  localparam int unsigned PWM_SYNC_MIN       = 2;
  localparam int unsigned PWM_RESOLUTION_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } pwm_cap_state_t;

endpackage

// File: rtl/pwm_input_sync.sv
// Synchronizer and edge detector for an asynchronous external input.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   async_i : asynchronous input
//   sync_o  : synchronized level, aligned with rise_o / fall_o
//   rise_o  : one-cycle pulse on a synchronized rising edge
//   fall_o  : one-cycle pulse on a synchronized falling edge
module pwm_input_sync
  import pwm_pkg::*;
#(
  parameter int unsigned SyncStages = PWM_SYNC_MIN
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], async_i};
    prev_d = sync_q[SyncStages-1];
    rise_d = sync_q[SyncStages-1] & ~prev_q;
    fall_d = ~sync_q[SyncStages-1] & prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Edge pulses are registered, so prev_q is the level that matches them.
  assign sync_o = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an external PWM input in
// prescaled ticks.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset
//   enable_i    : 1 = capture running, 0 = return to IDLE
//   prescale_i  : a tick occurs every prescale_i+1 clocks
//   pwm_i       : asynchronous PWM input
//   period_o    : last measured period (ticks)
//   high_time_o : last measured high time (ticks)
//   valid_o     : one-cycle pulse when period_o / high_time_o update
//   timeout_o   : counter saturated before the expected edge (level)
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned Resolution = PWM_RESOLUTION_DEF,
  parameter int unsigned SyncStages = PWM_SYNC_MIN
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [Resolution-1:0] prescale_i,
  input  logic                  pwm_i,
  output logic [Resolution-1:0] period_o,
  output logic [Resolution-1:0] high_time_o,
  output logic                  valid_o,
  output logic                  timeout_o
);

  logic                  pwm_lvl, rise, fall;
  logic                  tick, sat, high_end, low_end;
  logic [Resolution-1:0] cap_val;

  pwm_cap_state_t        state_q, state_d;
  logic [Resolution-1:0] presc_q, presc_d;
  logic [Resolution-1:0] cnt_q, cnt_d;
  logic [Resolution-1:0] high_tmp_q, high_tmp_d;
  logic [Resolution-1:0] period_q, period_d;
  logic [Resolution-1:0] high_time_q, high_time_d;
  logic                  valid_q, valid_d;
  logic                  timeout_q, timeout_d;

  pwm_input_sync #(
    .SyncStages(SyncStages)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .async_i(pwm_i),
    .sync_o (pwm_lvl),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    // ">=" so that lowering prescale_i mid-count wraps on the next clock.
    tick     = (presc_q >= prescale_i);
    // Ticks in the interval: start edge exclusive, end edge inclusive.
    cap_val  = cnt_q + Resolution'(tick);
    sat      = (cnt_q == '1) && tick;
    // Edges are only accepted when the synchronized level agrees.
    high_end = fall & ~pwm_lvl;
    low_end  = rise & pwm_lvl;

    state_d     = state_q;
    presc_d     = tick ? '0 : presc_q + Resolution'(1);
    cnt_d       = cap_val;
    high_tmp_d  = high_tmp_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!enable_i) begin
      state_d    = IDLE;
      presc_d    = '0;
      cnt_d      = '0;
      high_tmp_d = '0;
    end else begin
      // Every interval starts phase-aligned to its rising edge.
      if (rise) begin
        presc_d = '0;
      end
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (high_end) begin
            high_tmp_d = cap_val;
            state_d    = LOW;
          end else if (sat) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
        LOW: begin
          if (low_end) begin
            period_d    = cap_val;
            high_time_d = high_tmp_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = '0;
            state_d     = HIGH;
          end else if (sat) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      cnt_q       <= '0;
      high_tmp_q  <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      high_tmp_q  <= high_tmp_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period_o    = period_q;
  assign high_time_o = high_time_q;
  assign valid_o     = valid_q;
  assign timeout_o   = timeout_q;

endmodule
